// File: rtl/led_pkg.sv
// Shared constants for the LED pattern engine: mode codes, speed codes and
// the small enums used for bounce direction and fill phase.
package led_pkg;

  localparam logic [2:0] MODE_ROTL   = 3'd0;
  localparam logic [2:0] MODE_ROTR   = 3'd1;
  localparam logic [2:0] MODE_BOUNCE = 3'd2;
  localparam logic [2:0] MODE_BLINK  = 3'd3;
  localparam logic [2:0] MODE_FILL   = 3'd4;

  localparam logic [1:0] SPEED_X1 = 2'd0;
  localparam logic [1:0] SPEED_X2 = 2'd1;
  localparam logic [1:0] SPEED_X4 = 2'd2;
  localparam logic [1:0] SPEED_X8 = 2'd3;

  typedef enum logic {
    PhaseFill,
    PhaseDrain
  } fill_phase_e;

  typedef enum logic {
    DirLeft,
    DirRight
  } dir_e;

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts clk cycles and raises a single-cycle tick at the end
// of each period, where the period shrinks by powers of two with speed.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam logic [31:0] StepCycles = 32'(STEP_CYCLES);

  logic [31:0]      shifted;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] terminal;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    shifted = StepCycles;
    case (speed)
      SPEED_X1: shifted = StepCycles;
      SPEED_X2: shifted = StepCycles >> 1;
      SPEED_X4: shifted = StepCycles >> 2;
      SPEED_X8: shifted = StepCycles >> 3;
      default:  shifted = StepCycles;
    endcase
  end

  assign period   = CNT_W'(shifted);
  assign terminal = period - CNT_W'(1);

  // >= rather than == so a switch to a shorter period never lets cnt overrun.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q >= terminal) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern.sv
// LED pattern engine: rotate-left/right, bounce, blink and fill/drain patterns
// advanced by a prescaled tick; a mode change reloads the pattern immediately.
module led_pattern
  import led_pkg::*;
#(
  parameter int unsigned LED_W       = 8,
  parameter int unsigned STEP_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [1:0]       speed,
  output logic [LED_W-1:0] led,
  output logic             step
);

  logic [LED_W-1:0] led_q, led_d;
  logic             step_q, step_d;
  logic [2:0]       mode_q, mode_d;
  dir_e             dir_q, dir_d;
  fill_phase_e      phase_q, phase_d;
  logic             reload;
  logic             tick;
  logic [LED_W-1:0] fill_next;

  assign reload = (mode != mode_q);

  led_tick_gen #(
    .STEP_CYCLES(STEP_CYCLES),
    .CNT_W      (CNT_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (reload),
    .speed(speed),
    .tick (tick)
  );

  assign fill_next = {led_q[LED_W-2:0], phase_q == PhaseFill};

  always_comb begin
    led_d   = led_q;
    step_d  = 1'b0;
    mode_d  = mode_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    if (reload) begin
      mode_d  = mode;
      dir_d   = DirLeft;
      phase_d = PhaseFill;
      case (mode)
        MODE_ROTL, MODE_BOUNCE: led_d = LED_W'(1);
        MODE_ROTR:              led_d = {1'b1, {(LED_W-1){1'b0}}};
        MODE_BLINK, MODE_FILL:  led_d = '0;
        default:                led_d = led_q;
      endcase
    end else if (tick) begin
      step_d = 1'b1;
      case (mode_q)
        MODE_ROTL: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
        MODE_ROTR: led_d = {led_q[0], led_q[LED_W-1:1]};
        MODE_BOUNCE: begin
          // Reversal and the first move back happen in the same step.
          if (dir_q == DirLeft) begin
            if (led_q[LED_W-1]) begin
              dir_d = DirRight;
              led_d = led_q >> 1;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              dir_d = DirLeft;
              led_d = led_q << 1;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        MODE_BLINK: led_d = ~led_q;
        MODE_FILL: begin
          led_d = fill_next;
          if (phase_q == PhaseFill && (&fill_next)) begin
            phase_d = PhaseDrain;
          end else if (phase_q == PhaseDrain && fill_next == '0) begin
            phase_d = PhaseFill;
          end
        end
        default: step_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q   <= LED_W'(1);
      step_q  <= 1'b0;
      mode_q  <= MODE_ROTL;
      dir_q   <= DirLeft;
      phase_q <= PhaseFill;
    end else begin
      led_q   <= led_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule
